// File: rtl/mem_bus_master.sv
// Initiator side of the C2 cache-line bus: turns one cache request into a line
// READ/WRITE burst of 8 beats on the shared tri-state bus, guarded by a watchdog.
module mem_bus_master #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int TIMEOUT           = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic                                       req_write,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
  output logic                                       resp_valid,
  output logic                                       resp_err,
  output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                        data,
  inout  wire  [1:0]                                 command
);

  localparam int ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / BUS_SIZE;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_XFER, S_RELEASE} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic                resp_seen;
  logic                drive_cmd, drive_data;

  assign resp_seen = (command == CMD_RESPONSE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    beat_d       = beat_q;
    wdog_d       = wdog_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;

    // The RESPONSE test is always the if-branch so a floating bus takes the else path.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          beat_d     = '0;
          wdog_d     = '0;
          resp_err_d = 1'b0;
          state_d    = S_CMD;
        end
      end
      S_CMD: state_d = S_WAIT;
      S_WAIT, S_XFER: begin
        if (resp_seen) begin
          if (!write_q) rdata_d[BUS_SIZE*beat_q +: BUS_SIZE] = data;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = S_RELEASE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_XFER;
          end
        end else if (state_q == S_XFER || wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (resp_seen) begin
          state_d = S_RELEASE;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      beat_q       <= '0;
      wdog_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      beat_q       <= beat_d;
      wdog_q       <= wdog_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;
  assign address    = addr_q;

  // Bus drivers decode straight from state so reset releases the bus immediately.
  assign drive_cmd  = (state_q == S_CMD);
  assign drive_data = write_q && (state_q inside {S_CMD, S_WAIT, S_XFER});

  assign command = drive_cmd  ? (write_q ? CMD_WRITE : CMD_READ) : 2'bzz;
  assign data    = drive_data ? wdata_q[BUS_SIZE*beat_q +: BUS_SIZE] : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: a behavioural memory responder with a
// line-addressed store, directed corner cases, then randomized line traffic.
module tb_mem_bus_master;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [14:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid, resp_err;
  logic [127:0] resp_rdata;
  logic [14:0]  address;
  wire  [15:0]  data;
  wire  [1:0]   command;

  // Responder / probe drivers; the responder is reset together with the DUT.
  logic         rsp_cmd_en, rsp_data_en, probe_en;
  logic [1:0]   rsp_cmd;
  logic [15:0]  rsp_data;
  bit           rsp_present;
  int           rsp_beats;

  assign command = (rsp_cmd_en && reset) ? rsp_cmd : (probe_en ? 2'b00 : 2'bzz);
  assign data    = (rsp_data_en && reset) ? rsp_data : (probe_en ? 16'h0000 : 16'hzzzz);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;

  logic [127:0] mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .address    (address),
    .data       (data),
    .command    (command)
  );

  function automatic logic [127:0] get_line(input int a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: 5 idle cycles after the command, then rsp_beats RESPONSE beats.
  initial begin : responder
    int           a;
    bit           w;
    logic [127:0] line;
    rsp_cmd_en  = 1'b0;
    rsp_data_en = 1'b0;
    rsp_cmd     = 2'b00;
    rsp_data    = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset && rsp_present && (command == 2'b10 || command == 2'b11)) begin
        w    = (command == 2'b11);
        a    = int'(address);
        line = get_line(a);
        for (int i = 0; i < 5 && reset; i++) @(negedge clk);
        for (int b = 0; b < rsp_beats && reset; b++) begin
          rsp_cmd    = 2'b01;
          rsp_cmd_en = 1'b1;
          if (!w) begin
            rsp_data    = line[16*b +: 16];
            rsp_data_en = 1'b1;
          end else begin
            line[16*b +: 16] = data;
            mem[a] = line;
          end
          @(negedge clk);
        end
        rsp_cmd_en  = 1'b0;
        rsp_data_en = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic start_req(input bit w, input logic [14:0] a, input logic [127:0] d,
                           input bit hold);
    int n;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic finish_req(input logic [14:0] a, input bit exp_err, input int exp_lat,
                            input bit chk_rdata, input logic [127:0] exp_rdata,
                            input bit chk_pulse);
    int n, cmd_cycles, ready_busy;
    bit seen;
    n = 0; cmd_cycles = 0; ready_busy = 0; seen = 1'b0;
    check("address", address, a);
    while (!seen && n < 300) begin
      if (command == 2'b10 || command == 2'b11) cmd_cycles++;
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (req_ready === 1'b1) ready_busy++;
        @(negedge clk);
        n++;
      end
    end
    check("resp_seen", seen, 1'b1);
    check("latency", cyc - acc_cyc, exp_lat);
    check("resp_err", resp_err, exp_err);
    check("cmd_cycles", cmd_cycles, 1);
    check("ready_busy", ready_busy, 0);
    if (chk_rdata) check("rdata", resp_rdata, exp_rdata);
    if (chk_pulse) begin
      @(negedge clk);
      check("resp_pulse", resp_valid, 1'b0);
    end
  endtask

  task automatic probe_bus(input string tag);
    probe_en = 1'b1;
    #1;
    check({tag, "_data_free"}, data, 16'h0000);
    check({tag, "_cmd_free"}, command, 2'b00);
    probe_en = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [127:0] d, d2, exp;
    logic [14:0]  a;
    bit           w;
    int           acc1, pulses;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    probe_en = 1'b0; rsp_present = 1'b1; rsp_beats = 8;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_err", resp_err, 1'b0);
    check("rst_rdata", resp_rdata, '0);
    check("rst_addr", address, '0);
    probe_bus("rst");
    reset = 1'b1;
    @(negedge clk);

    // Known line read: 14 edges from accept to the resp_valid cycle.
    mem[5] = 128'h00112233445566778899AABBCCDDEEFF;
    start_req(1'b0, 15'h0005, '0, 1'b0);
    finish_req(15'h0005, 1'b0, 14, 1'b1, 128'h00112233445566778899AABBCCDDEEFF, 1'b1);

    // Write a line, confirm what memory sampled, then read it back.
    d = 128'hA5A5_5A5A_F0F0_0F0F_A5A5_5A5A_F0F0_0F0F;
    start_req(1'b1, 15'h0010, d, 1'b0);
    finish_req(15'h0010, 1'b0, 14, 1'b0, '0, 1'b1);
    check("wr_mem", mem[16], d);
    probe_bus("after_wr");
    start_req(1'b0, 15'h0010, '0, 1'b0);
    finish_req(15'h0010, 1'b0, 14, 1'b1, d, 1'b1);

    // Back-to-back with req_valid held: second accept the edge after resp_valid.
    exp = get_line(32'h20);
    d2  = {$urandom, $urandom, $urandom, $urandom};
    start_req(1'b0, 15'h0020, '0, 1'b1);
    acc1      = acc_cyc;
    req_write = 1'b1;
    req_addr  = 15'h0021;
    req_wdata = d2;
    finish_req(15'h0020, 1'b0, 14, 1'b1, exp, 1'b0);
    start_req(1'b1, 15'h0021, d2, 1'b0);
    check("b2b_gap", acc_cyc - acc1, 15);
    finish_req(15'h0021, 1'b0, 14, 1'b0, '0, 1'b1);
    check("b2b_wr_mem", mem[33], d2);

    // No responder: 1 CMD edge + 64 WAIT edges, then an error completion.
    rsp_present = 1'b0;
    start_req(1'b0, 15'h0030, '0, 1'b0);
    finish_req(15'h0030, 1'b1, 65, 1'b0, '0, 1'b1);
    check("to_ready", req_ready, 1'b1);
    probe_bus("timeout");
    rsp_present = 1'b1;
    @(negedge clk);

    // Responder gives only 3 beats: error at the 4th beat edge.
    rsp_beats = 3;
    exp = get_line(32'h40);
    start_req(1'b0, 15'h0040, '0, 1'b0);
    finish_req(15'h0040, 1'b1, 9, 1'b0, '0, 1'b1);
    check("drop_ready", req_ready, 1'b1);
    probe_bus("drop");
    rsp_beats = 8;
    @(negedge clk);

    // Reset just before the beat-4 edge of a write.
    start_req(1'b1, 15'h7ABC, d, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_err", resp_err, 1'b0);
    check("mid_rst_rdata", resp_rdata, '0);
    check("mid_rst_addr", address, '0);
    probe_bus("mid_rst");
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (resp_valid === 1'b1) pulses++;
    check("mid_rst_no_pulse", pulses, 0);
    exp = get_line(32'h50);
    start_req(1'b0, 15'h0050, '0, 1'b0);
    finish_req(15'h0050, 1'b0, 14, 1'b1, exp, 1'b1);

    // Randomized traffic over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 15'h0100 + 15'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      if (w) begin
        start_req(1'b1, a, d, 1'b0);
        finish_req(a, 1'b0, 14, 1'b0, '0, 1'b1);
        check("rand_wr_mem", mem[int'(a)], d);
      end else begin
        exp = get_line(int'(a));
        start_req(1'b0, a, '0, 1'b0);
        finish_req(a, 1'b0, 14, 1'b1, exp, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
